// File: rtl/io_tile_pkg.sv
// Shared constants and FSM state type for the logical IO tile.
package io_tile_pkg;

  localparam int unsigned CFG_BITS    = 4;
  localparam int unsigned CFG_EN      = 0;
  localparam int unsigned CFG_IN_REG  = 1;
  localparam int unsigned CFG_OUT_REG = 2;
  localparam int unsigned CFG_INV     = 3;

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,
    ST_PROG   = 2'd1,
    ST_LOCKED = 2'd2
  } io_state_e;

endpackage

// File: rtl/io_pad_slice.sv
// Per-pad datapath: tristate pad cell, inversion, optional output register
// and optional 2-flop input synchronizer, all gated off until the tile locks.
module io_pad_cell (
  input  logic oe,
  input  logic dout,
  output logic din,
  inout  wire  pad
);

  assign pad = oe ? dout : 1'bz;
  assign din = pad;

endmodule

module io_pad_slice
  import io_tile_pkg::*;
(
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                locked,
  input  logic [CFG_BITS-1:0] cfg,
  input  logic                outpad,
  output logic                inpad,
  inout  wire                 pad
);

  logic out_val;
  logic out_q;
  logic drive_val;
  logic oe;
  logic pad_in;
  logic in_val;
  logic sync1_q;
  logic sync2_q;

  assign out_val   = outpad ^ cfg[CFG_INV];
  assign drive_val = cfg[CFG_OUT_REG] ? out_q : out_val;
  assign oe        = locked & cfg[CFG_EN];
  assign in_val    = pad_in ^ cfg[CFG_INV];

  io_pad_cell u_cell (
    .oe   (oe),
    .dout (drive_val),
    .din  (pad_in),
    .pad  (pad)
  );

  // Datapath flops are held at zero until the configuration is locked.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      out_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else if (!locked) begin
      out_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      out_q   <= out_val;
      sync1_q <= in_val;
      sync2_q <= sync1_q;
    end
  end

  assign inpad = locked ? (cfg[CFG_IN_REG] ? sync2_q : in_val) : 1'b0;

endmodule

// File: rtl/logical_tile_io_array.sv
// IO tile array: config FSM, per-pad config storage, address decode and
// registered readback, driving N_PADS io_pad_slice instances.
module logical_tile_io_array
  import io_tile_pkg::*;
#(
  parameter  int unsigned N_PADS = 8,
  localparam int unsigned ADDR_W = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  inout  wire  [N_PADS-1:0]   gfpga_pad_iopad_pad,
  input  logic [N_PADS-1:0]   io_outpad,
  output logic [N_PADS-1:0]   io_inpad,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   address,
  input  logic [CFG_BITS-1:0] data_in,
  input  logic                cfg_lock,
  output logic [CFG_BITS-1:0] cfg_rdata,
  output logic                cfg_locked,
  output logic                cfg_err
);

  io_state_e           state_q;
  io_state_e           state_d;
  logic [CFG_BITS-1:0] cfg_q [N_PADS];
  logic [CFG_BITS-1:0] rd_word;
  logic                addr_ok;
  logic                is_locked;
  logic                wr_legal;
  logic                wr_illegal;

  assign addr_ok = 32'(address) < N_PADS;

  // State register
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) state_q <= ST_UNCONF;
    else           state_q <= state_d;
  end

  // Next-state logic; lock wins over the first-write transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNCONF: begin
        if (cfg_lock)      state_d = ST_LOCKED;
        else if (wr_legal) state_d = ST_PROG;
      end
      ST_PROG:   if (cfg_lock) state_d = ST_LOCKED;
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_UNCONF;
    endcase
  end

  // Output decode
  always_comb begin
    is_locked  = 1'b0;
    wr_legal   = 1'b0;
    wr_illegal = 1'b0;
    if (state_q == ST_LOCKED) is_locked = 1'b1;
    if (enable) begin
      if (!is_locked && addr_ok) wr_legal   = 1'b1;
      else                       wr_illegal = 1'b1;
    end
  end

  // Config storage
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      for (int i = 0; i < int'(N_PADS); i++) cfg_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_PADS); i++) begin
        if (wr_legal && (address == ADDR_W'(i))) cfg_q[i] <= data_in;
      end
    end
  end

  // Readback mux; out-of-range addresses read as zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(N_PADS); i++) begin
      if (address == ADDR_W'(i)) rd_word = cfg_q[i];
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_rdata <= addr_ok ? rd_word : '0;
      cfg_err   <= cfg_err | wr_illegal;
    end
  end

  assign cfg_locked = is_locked;

  for (genvar g = 0; g < int'(N_PADS); g++) begin : g_pad
    io_pad_slice u_slice (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .locked   (is_locked),
      .cfg      (cfg_q[g]),
      .outpad   (io_outpad[g]),
      .inpad    (io_inpad[g]),
      .pad      (gfpga_pad_iopad_pad[g])
    );
  end

endmodule

// File: tb/tb_logical_tile_io_array.sv
// Directed self-checking bench for logical_tile_io_array. Pads carry weak
// pull-ups, so an undriven (Z) pad reads back as 1.
module tb_logical_tile_io_array;

  localparam int unsigned N = 8;
  localparam int unsigned AW = 3;

  logic          prog_clk = 1'b0;
  logic          pReset_n;
  wire  [N-1:0]  pad;
  logic [N-1:0]  io_outpad;
  logic [N-1:0]  io_inpad;
  logic          enable;
  logic [AW-1:0] address;
  logic [3:0]    data_in;
  logic          cfg_lock;
  logic [3:0]    cfg_rdata;
  logic          cfg_locked;
  logic          cfg_err;
  logic [N-1:0]  ext_oe;
  logic [N-1:0]  ext_val;

  int tests = 0;
  int fails = 0;

  always #5 prog_clk = ~prog_clk;

  for (genvar g = 0; g < int'(N); g++) begin : g_ext
    pullup pu (pad[g]);
    assign pad[g] = ext_oe[g] ? ext_val[g] : 1'bz;
  end

  logical_tile_io_array #(.N_PADS(N)) dut (
    .prog_clk            (prog_clk),
    .pReset_n            (pReset_n),
    .gfpga_pad_iopad_pad (pad),
    .io_outpad           (io_outpad),
    .io_inpad            (io_inpad),
    .enable              (enable),
    .address             (address),
    .data_in             (data_in),
    .cfg_lock            (cfg_lock),
    .cfg_rdata           (cfg_rdata),
    .cfg_locked          (cfg_locked),
    .cfg_err             (cfg_err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  initial begin
    pReset_n  = 1'b0;
    io_outpad = '0;
    enable    = 1'b0;
    address   = '0;
    data_in   = '0;
    cfg_lock  = 1'b0;
    ext_oe    = '0;
    ext_val   = '0;
    step();
    step();
    check("rst_locked", 8'(cfg_locked), 8'h0);
    check("rst_err", 8'(cfg_err), 8'h0);
    check("rst_pads_z", pad, 8'hFF);
    check("rst_inpad", io_inpad, 8'h00);
    check("rst_rdata", 8'(cfg_rdata), 8'h0);
    pReset_n = 1'b1;

    // All addresses read zero after reset
    for (int a = 0; a < int'(N); a++) begin
      address = AW'(a);
      step();
      check($sformatf("rd0_addr%0d", a), 8'(cfg_rdata), 8'h0);
    end
    check("unconf_pads_z", pad, 8'hFF);
    check("unconf_inpad", io_inpad, 8'h00);

    // Program pad 3: EN | OUT_REG
    address = 3'd3; data_in = 4'b0101; enable = 1'b1;
    step();
    enable = 1'b0;
    check("prog_not_locked", 8'(cfg_locked), 8'h0);
    check("prog_pads_z", pad, 8'hFF);
    step();
    check("rd_pad3", 8'(cfg_rdata), 8'h5);

    // Program pad 5: IN_REG | INV
    address = 3'd5; data_in = 4'b1010; enable = 1'b1;
    step();
    enable = 1'b0;

    // Write pad 0 and lock on the same edge
    address = 3'd0; data_in = 4'b0001; enable = 1'b1; cfg_lock = 1'b1;
    check("prelock_locked", 8'(cfg_locked), 8'h0);
    step();
    enable = 1'b0; cfg_lock = 1'b0;
    check("lock_same_edge", 8'(cfg_locked), 8'h1);
    step();
    check("rd_pad0", 8'(cfg_rdata), 8'h1);
    check("lock_no_err", 8'(cfg_err), 8'h0);
    check("locked_pads", pad, 8'hF6);
    check("locked_inpad", io_inpad, 8'hD6);

    // Registered output on pad 3, combinational on pad 0
    io_outpad[3] = 1'b1;
    io_outpad[0] = 1'b1;
    #1;
    check("pad3_before_edge", 8'(pad[3]), 8'h0);
    check("pad0_comb", 8'(pad[0]), 8'h1);
    check("inpad0_loop", 8'(io_inpad[0]), 8'h1);
    step();
    check("pad3_after_edge", 8'(pad[3]), 8'h1);
    check("inpad3_loop", 8'(io_inpad[3]), 8'h1);
    address = 3'd3;
    step();
    check("rd_pad3_locked", 8'(cfg_rdata), 8'h5);

    // Pad 5 driven externally low, inverted through 2-flop sync
    ext_oe[5] = 1'b1; ext_val[5] = 1'b0;
    #1;
    check("pad5_ext", 8'(pad[5]), 8'h0);
    check("inpad5_edge0", 8'(io_inpad[5]), 8'h0);
    step();
    check("inpad5_edge1", 8'(io_inpad[5]), 8'h0);
    step();
    check("inpad5_edge2", 8'(io_inpad[5]), 8'h1);
    ext_oe[5] = 1'b0;

    // Write after lock is ignored and flags a sticky error
    address = 3'd3; data_in = 4'b1111; enable = 1'b1;
    step();
    enable = 1'b0;
    check("err_set", 8'(cfg_err), 8'h1);
    step();
    check("rd_pad3_unchanged", 8'(cfg_rdata), 8'h5);
    check("err_sticky", 8'(cfg_err), 8'h1);
    check("pad3_still_driven", 8'(pad[3]), 8'h1);

    // Drive pads low, then reset mid-write while locked
    io_outpad = '0;
    step();
    check("pre_reset_pads", pad, 8'hF6);
    enable = 1'b1; address = 3'd3; data_in = 4'b1111;
    pReset_n = 1'b0;
    #1;
    check("reset_pads_z", pad, 8'hFF);
    check("reset_locked", 8'(cfg_locked), 8'h0);
    check("reset_err", 8'(cfg_err), 8'h0);
    check("reset_inpad", io_inpad, 8'h00);
    check("reset_rdata", 8'(cfg_rdata), 8'h0);
    step();

    // First write accepted on the first edge after release
    address = 3'd2; data_in = 4'b0011; enable = 1'b1;
    pReset_n = 1'b1;
    step();
    enable = 1'b0;
    check("post_reset_unlocked", 8'(cfg_locked), 8'h0);
    address = 3'd0;
    step();
    check("rd_pad0_cleared", 8'(cfg_rdata), 8'h0);
    address = 3'd3;
    step();
    check("rd_pad3_cleared", 8'(cfg_rdata), 8'h0);
    address = 3'd5;
    step();
    check("rd_pad5_cleared", 8'(cfg_rdata), 8'h0);
    address = 3'd2;
    step();
    check("rd_pad2_first_write", 8'(cfg_rdata), 8'h3);
    check("post_reset_pads_z", pad, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logical_tile_io_array.md
LOGICAL_TILE_IO_ARRAY -- requirements
Module: logical_tile_io_array

Interface
REQ-001 Parameters SHALL be as follows:
- N_PADS, default 8, number of IO pads (range 1..64).
- ADDR_W, default $clog2(N_PADS) with a minimum of 1, config address width (derived, not overridden).

REQ-002 Ports SHALL be as follows:
- prog_clk  input  1  single clock for configuration and registered datapath.
- pReset_n  input  1  asynchronous active-low reset.
- gfpga_pad_iopad_pad  inout  N_PADS  device pads.
- io_outpad  input  N_PADS  fabric-to-pad data.
- io_inpad  output  N_PADS  pad-to-fabric data.
- enable  input  1  config write strobe.
- address  input  ADDR_W  pad index for write and readback.
- data_in  input  4  config word.
- cfg_lock  input  1  lock request.
- cfg_rdata  output  4  registered readback of the config word at address.
- cfg_locked  output  1  high in LOCKED.
- cfg_err  output  1  sticky illegal-write flag.

REQ-003 Clock and reset SHALL be one clock, prog_clk, with pReset_n asynchronous and active-low.

Function
REQ-004 Each pad SHALL hold a 4-bit config word: bit0 EN (output driver on), bit1 IN_REG, bit2 OUT_REG, bit3 INV.
REQ-005 The FSM SHALL have three states: UNCONF (after reset), PROG, LOCKED.
REQ-006 FSM transitions SHALL be:
- UNCONF->PROG on the first legal write.
- UNCONF or PROG->LOCKED on cfg_lock.
- LOCKED is left only by reset.
REQ-007 A legal write (enable=1, state!=LOCKED, address<N_PADS) SHALL update cfg[address]<=data_in at the prog_clk edge.
REQ-008 A write in LOCKED or with address>=N_PADS SHALL be ignored and SHALL set cfg_err=1, which stays set until reset.
REQ-009 On enable and cfg_lock in the same cycle in UNCONF/PROG, the write SHALL take effect and the state SHALL become LOCKED in that same edge.
REQ-010 cfg_rdata SHALL equal cfg[address] sampled one cycle earlier; an out-of-range address SHALL return 4'b0000.
REQ-011 While not LOCKED, every pad driver SHALL be disabled (Z), io_inpad SHALL be 0, and datapath registers SHALL hold 0.
REQ-012 In LOCKED with EN=1, the pad SHALL be driven by the output value:
- OUT_REG=0: io_outpad XOR INV, combinational.
- OUT_REG=1: the same value through one prog_clk register (latency 1).
REQ-013 In LOCKED with EN=0, the pad SHALL be Z.
REQ-014 In LOCKED, io_inpad SHALL be the pad value XOR INV:
- IN_REG=0: combinational.
- IN_REG=1: through a 2-flop synchronizer (latency 2 edges).
REQ-015 With EN=1, io_inpad SHALL reflect the driven pad value (loopback), subject to the same IN_REG latency.

Reset
REQ-016 pReset_n=0 SHALL immediately force:
- state=UNCONF;
- all cfg words, cfg_rdata, sync and output registers to 0;
- cfg_locked=0, cfg_err=0;
- all pads Z, io_inpad=0.
REQ-017 Reset asserted mid-write or while LOCKED SHALL discard that write and return the block to UNCONF.
REQ-018 Deassertion SHALL be sampled synchronously; the first write is accepted on the first prog_clk edge after release.

Structure
REQ-019 Package io_tile_pkg SHALL hold CFG_BITS=4, bit-index constants (CFG_EN, CFG_IN_REG, CFG_OUT_REG, CFG_INV) and the FSM state enum.
REQ-020 Sub-module io_pad_slice SHALL contain the per-pad datapath (iopad cell instance, INV, output register, 2-flop sync, lock gating), instantiated N_PADS times.
REQ-021 The FSM, config storage, address decode and readback SHALL live in the top module.

Verification
REQ-022 Reset, then read all addresses -> cfg_rdata=0, pads Z, io_inpad=0, cfg_locked=0, cfg_err=0.
REQ-023 Write pad 3 with 4'b0101 (EN, OUT_REG), lock, set io_outpad[3]=1 -> pad[3]=1 one edge later; readback of address 3 = 4'b0101.
REQ-024 Pad 5 with 4'b1010 (IN_REG, INV), locked, external pad[5]=0 -> io_inpad[5]=1 exactly two edges later; pad[5] stays Z.
REQ-025 Write after lock, and a write to address N_PADS (when N_PADS is not a power of two) -> cfg unchanged, cfg_err=1 and stays set.
REQ-026 enable and cfg_lock in the same cycle with data 4'b0001 on pad 0 -> cfg[0]=4'b0001 and cfg_locked=1 on the same edge.
REQ-027 pReset_n pulse while LOCKED with pads driving -> pads Z immediately, state UNCONF, all cfg words 0.
